// File: rtl/instruction_fetch.sv
// Instruction fetch front end: issues one BRAM word read per cycle and buffers the
// one-cycle-late responses in a 2-entry FIFO feeding decode over valid/ready.
module instruction_fetch #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [31:0]           instr_pc
);

    localparam int unsigned PC_WIDTH     = 32;
    localparam int unsigned COUNT_WIDTH  = 2;
    localparam int unsigned CREDIT_WIDTH = 3;
    localparam logic [PC_WIDTH-1:0] PC_STEP    = 32'd4;
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [PC_WIDTH-1:0] RESET_BASE = RESET_PC & ALIGN_MASK;
    localparam logic [ADDR_WIDTH-1:0] RESET_WORD = RESET_BASE[ADDR_WIDTH+1:2];
    localparam logic [CREDIT_WIDTH-1:0] FIFO_DEPTH = 3'd2;

    typedef struct packed {
        logic [PC_WIDTH-1:0]   pc;
        logic [DATA_WIDTH-1:0] data;
    } fetch_entry_t;

    logic [PC_WIDTH-1:0]     pc;
    logic [PC_WIDTH-1:0]     pc_next;
    logic [PC_WIDTH-1:0]     tag_pc;
    logic [PC_WIDTH-1:0]     tag_pc_next;
    logic                    inflight;
    logic                    inflight_next;
    logic [COUNT_WIDTH-1:0]  count;
    logic [COUNT_WIDTH-1:0]  count_next;
    fetch_entry_t            head;
    fetch_entry_t            head_next;
    fetch_entry_t            tail;
    fetch_entry_t            tail_next;
    fetch_entry_t            new_entry;

    logic [PC_WIDTH-1:0]     redirect_base;
    logic [CREDIT_WIDTH-1:0] credit;
    logic [COUNT_WIDTH-1:0]  push_slot;
    logic                    pop;
    logic                    push;
    logic                    issue;

    // Decode never sees a transfer in a redirect cycle.
    assign instr_valid = (count != 2'd0) & ~redirect_valid;
    assign instr_data  = head.data;
    assign instr_pc    = head.pc;

    // Redirect target is presented to the BRAM in the same cycle.
    always_comb begin
        mem_addr = pc[ADDR_WIDTH+1:2];
        if (rst) begin
            mem_addr = RESET_WORD;
        end else if (redirect_valid) begin
            mem_addr = redirect_pc[ADDR_WIDTH+1:2];
        end
    end

    // Issue credit counts buffered entries plus the response still on its way.
    always_comb begin
        redirect_base = redirect_pc & ALIGN_MASK;
        pop           = instr_valid & instr_ready;
        push          = inflight & ~redirect_valid;
        credit        = CREDIT_WIDTH'(count) + CREDIT_WIDTH'(inflight) - CREDIT_WIDTH'(pop);
        issue         = enable & (redirect_valid | (credit < FIFO_DEPTH));
    end

    // PC, tag and in-flight tracking.
    always_comb begin
        pc_next       = pc;
        tag_pc_next   = tag_pc;
        inflight_next = 1'b0;
        if (redirect_valid) begin
            if (enable) begin
                pc_next       = redirect_base + PC_STEP;
                tag_pc_next   = redirect_base;
                inflight_next = 1'b1;
            end else begin
                pc_next = redirect_base;
            end
        end else if (issue) begin
            pc_next       = pc + PC_STEP;
            tag_pc_next   = pc;
            inflight_next = 1'b1;
        end
    end

    // Two-entry FIFO kept as head/tail registers so the head never moves while stalled.
    always_comb begin
        new_entry = '{pc: tag_pc, data: mem_data};
        head_next = head;
        tail_next = tail;
        push_slot = count - COUNT_WIDTH'(pop);
        if (redirect_valid) begin
            count_next = '0;
        end else begin
            count_next = count + COUNT_WIDTH'(push) - COUNT_WIDTH'(pop);
            if (pop) begin
                head_next = tail;
            end
            if (push) begin
                case (push_slot)
                    2'd0:    head_next = new_entry;
                    2'd1:    tail_next = new_entry;
                    default: tail_next = tail;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_BASE;
            tag_pc   <= '0;
            inflight <= 1'b0;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            pc       <= pc_next;
            tag_pc   <= tag_pc_next;
            inflight <= inflight_next;
            count    <= count_next;
            head     <= head_next;
            tail     <= tail_next;
        end
    end

endmodule
